vmax_row_pooler: RTL and testbench

Sequential vertical max-pooling engine on the producer side of the systolic-array max-pool path. It accepts a stream of HMax rows (one signed value per SA column) over a valid/ready handshake and keeps the last F rows in a circular buffer. Each time a pooling window completes, it reduces the buffered rows column-wise to their maximum and emits one pooled row downstream. Window size, stride and feature-map height are runtime-configurable up to MAX_FILTER_SIZE.

---
 rtl/vmax_row_pooler.sv | 158 +++++++++++++++
 tb/tb_vmax_row_pooler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmax_row_pooler.sv
// Vertical max-pool: buffers the last F HMax rows and emits the column-wise max per window.
// Ports: clk/rst, start+cfg_*, in_valid/in_ready/in_row, out_valid/out_ready/out_row/out_last, busy/done/cfg_err.
module vmax_row_pooler #(
    parameter int DATA_WIDTH      = 32,
    parameter int SA_LENGTH       = 10,
    parameter int MAX_FILTER_SIZE = 7,
    parameter int CW              = $clog2(MAX_FILTER_SIZE + 1),
    parameter int HW              = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CW-1:0]                cfg_filter_size,
    input  logic [CW-1:0]                cfg_stride,
    input  logic [HW-1:0]                cfg_rows,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_row [SA_LENGTH],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_row [SA_LENGTH],
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_REDUCE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0] f, s, wptr, togo, k;
    logic [HW-1:0] h, r, r_inc;
    logic          err;
    logic          cfg_bad, accept, take, last;
    logic [HW:0]   r_plus_s;

    logic signed [DATA_WIDTH-1:0] rowbuf [MAX_FILTER_SIZE][SA_LENGTH];
    logic signed [DATA_WIDTH-1:0] rd  [SA_LENGTH];
    logic signed [DATA_WIDTH-1:0] acc [SA_LENGTH];

    assign cfg_bad = (cfg_filter_size == '0)
                  || (int'(cfg_filter_size) > MAX_FILTER_SIZE)
                  || (cfg_stride == '0)
                  || (cfg_rows < HW'(cfg_filter_size));

    assign accept   = (state == S_FILL) && in_valid;
    assign take     = (state == S_EMIT) && out_ready;
    assign r_inc    = r + HW'(1);
    assign r_plus_s = {1'b0, r} + (HW+1)'(s);
    // Final window: the next one would run past the map.
    assign last     = (r_plus_s > {1'b0, h}) || (r == h);

    assign in_ready  = (state == S_FILL);
    assign out_valid = (state == S_EMIT);
    assign out_last  = (state == S_EMIT) && last;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign cfg_err   = err;
    assign out_row   = acc;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = cfg_bad ? S_DONE : S_FILL;
            S_FILL: begin
                if (accept) begin
                    // togo hits 1 exactly on r = F, F+S, F+2S, ...
                    if (togo == CW'(1))
                        state_nx = S_REDUCE;
                    else if (r_inc == h)
                        state_nx = S_DONE;
                end
            end
            // Rows past the final window are still drained in FILL.
            S_REDUCE: if (k == f) state_nx = S_EMIT;
            S_EMIT:   if (take) state_nx = (r == h) ? S_DONE : S_FILL;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            f     <= '0;
            s     <= '0;
            h     <= '0;
            r     <= '0;
            wptr  <= '0;
            togo  <= '0;
            k     <= '0;
            err   <= 1'b0;
            for (int c = 0; c < SA_LENGTH; c++) begin
                rd[c]  <= '0;
                acc[c] <= '0;
            end
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        f    <= cfg_filter_size;
                        s    <= cfg_stride;
                        h    <= cfg_rows;
                        r    <= '0;
                        wptr <= '0;
                        togo <= cfg_filter_size;
                        err  <= cfg_bad;
                    end
                end
                S_FILL: begin
                    k <= '0;
                    if (accept) begin
                        r    <= r_inc;
                        wptr <= (wptr == f - CW'(1)) ? '0 : wptr + CW'(1);
                        togo <= (togo == CW'(1)) ? s : togo - CW'(1);
                    end
                end
                S_REDUCE: begin
                    // Registered buffer read; the max lags the read by one cycle.
                    k <= k + CW'(1);
                    if (k < f)
                        rd <= rowbuf[k];
                    if (k == CW'(1))
                        acc <= rd;
                    else if (k > CW'(1)) begin
                        for (int c = 0; c < SA_LENGTH; c++)
                            if (rd[c] > acc[c])
                                acc[c] <= rd[c];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            rowbuf[wptr] <= in_row;
    end

    a_excl: assert property (@(posedge clk) disable iff (rst)
        !(out_valid && in_ready));

    a_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_last)));

    a_one: assert property (@(posedge clk) disable iff (rst)
        $rose(out_valid) |-> ($past(state) == S_REDUCE));

endmodule

// File: tb/tb_vmax_row_pooler.sv
// Scoreboard bench for vmax_row_pooler.
// Expected pooled rows are computed from the accepted-input history.
module tb_vmax_row_pooler;

    localparam int DW = 32;
    localparam int SA = 10;
    localparam int MF = 7;
    localparam int CW = $clog2(MF + 1);
    localparam int HW = 16;

    typedef logic [SA-1:0][DW-1:0] row_t;
    typedef struct packed {
        row_t        row;
        logic        last;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start;
    logic [CW-1:0] cfg_filter_size, cfg_stride;
    logic [HW-1:0] cfg_rows;
    logic in_valid, in_ready, out_valid, out_ready;
    logic out_last, busy, done, cfg_err;
    logic signed [DW-1:0] in_row  [SA];
    logic signed [DW-1:0] out_row [SA];

    vmax_row_pooler #(
        .DATA_WIDTH(DW), .SA_LENGTH(SA), .MAX_FILTER_SIZE(MF),
        .CW(CW), .HW(HW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_filter_size(cfg_filter_size), .cfg_stride(cfg_stride),
        .cfg_rows(cfg_rows), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_last(out_last), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int m_f, m_s, m_h, m_r;
    int last_evt, done_cyc, done_cnt, n_out;
    bit ov_prev, hold_chk;
    row_t held, cur, w;
    exp_t e, q[$];
    row_t hist[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, longint got, longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic row_t mk(int v);
        row_t t;
        for (int c = 0; c < SA; c++) t[c] = DW'(v + c);
        return t;
    endfunction

    function automatic row_t rnd_row();
        row_t t;
        for (int c = 0; c < SA; c++)
            t[c] = DW'(int'($urandom_range(0, 2000)) - 1000);
        return t;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            ov_prev  = 1'b0;
            hold_chk = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                for (int c = 0; c < SA; c++) w[c] = in_row[c];
                hist.push_back(w);
                m_r++;
                last_evt = cyc + 1;
                if (m_s > 0 && m_r >= m_f && (m_r - m_f) % m_s == 0) begin
                    e.row = hist[hist.size() - m_f];
                    for (int i = hist.size() - m_f + 1; i < hist.size(); i++)
                        for (int c = 0; c < SA; c++)
                            if ($signed(hist[i][c]) > $signed(e.row[c]))
                                e.row[c] = hist[i][c];
                    e.last = (m_r + m_s > m_h) || (m_r == m_h);
                    e.cyc  = 32'(cyc + 1);
                    q.push_back(e);
                end
            end
            if (out_valid) begin
                for (int c = 0; c < SA; c++) cur[c] = out_row[c];
                if (in_ready) check("excl", 1, 0);
                if (!ov_prev) begin
                    if (q.size() == 0) check("spurious", 1, 0);
                    else check("latency", cyc - int'(q[0].cyc), m_f + 1);
                end else if (hold_chk) begin
                    check("hold_row", longint'(cur == held), 1);
                end
                if (out_ready) begin
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        for (int c = 0; c < SA; c++)
                            check("out_row", $signed(out_row[c]), $signed(e.row[c]));
                        check("out_last", out_last, e.last);
                    end
                    n_out++;
                    last_evt = cyc + 1;
                    hold_chk = 1'b0;
                end else begin
                    held     = cur;
                    hold_chk = 1'b1;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            ov_prev = out_valid;
        end
    end

    task automatic start_map(int f, int s, int h);
        @(posedge clk); #1;
        cfg_filter_size = CW'(f);
        cfg_stride      = CW'(s);
        cfg_rows        = HW'(h);
        m_f = f; m_s = s; m_h = h; m_r = 0;
        hist.delete(); q.delete();
        n_out = 0; done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_row(row_t v);
        int t;
        t = 0;
        in_valid = 1'b1;
        for (int c = 0; c < SA; c++) in_row[c] = v[c];
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) check("in_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_map(int f, int s, int h);
        int t;
        t = 0;
        while (done_cnt == 0 && t < 500) begin
            t++;
            @(posedge clk);
        end
        #1;
        check("done_seen", done_cnt, 1);
        check("done_time", done_cyc, last_evt);
        check("q_empty", q.size(), 0);
        check("n_out", n_out, (h - f) / s + 1);
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
        check("done_once", done_cnt, 1);
    endtask

    task automatic run_map(int f, int s, int h, row_t rows[$]);
        start_map(f, s, h);
        check("cfg_err_clr", cfg_err, 0);
        check("busy", busy, 1);
        foreach (rows[i]) send_row(rows[i]);
        finish_map(f, s, h);
    endtask

    task automatic bad_cfg(int f, int s, int h);
        @(posedge clk); #1;
        cfg_filter_size = CW'(f);
        cfg_stride      = CW'(s);
        cfg_rows        = HW'(h);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("bad_err", cfg_err, 1);
        check("bad_done", done, 1);
        check("bad_in_ready", in_ready, 0);
        check("bad_out_valid", out_valid, 0);
        @(posedge clk); #1;
        check("bad_done_off", done, 0);
        check("bad_idle", busy, 0);
        check("bad_err_sticky", cfg_err, 1);
        check("bad_in_ready2", in_ready, 0);
    endtask

    row_t rows[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_filter_size = '0; cfg_stride = '0; cfg_rows = '0;
        m_f = 0; m_s = 0; m_h = 0; m_r = 0;
        last_evt = 0; done_cyc = 0; done_cnt = 0; n_out = 0;
        for (int c = 0; c < SA; c++) in_row[c] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_out_row", out_row[0], 0);
        rst = 1'b0;

        rows = '{mk(642), mk(905), mk(248), mk(834)};
        run_map(2, 2, 4, rows);

        rows = '{mk(-5), mk(-1), mk(-9), mk(-3), mk(-7)};
        run_map(3, 1, 5, rows);

        rows = '{rnd_row(), rnd_row(), rnd_row()};
        fork
            run_map(2, 1, 3, rows);
            begin
                int t;
                t = 0;
                out_ready = 1'b0;
                @(negedge clk);
                while (!out_valid && t < 200) begin
                    t++;
                    @(negedge clk);
                end
                if (t >= 200) check("stall_timeout", 0, 1);
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join

        rows.delete();
        for (int i = 0; i < 7; i++) rows.push_back(rnd_row());
        run_map(2, 3, 7, rows);

        bad_cfg(0, 1, 4);
        bad_cfg(8, 1, 8);
        bad_cfg(2, 0, 4);
        bad_cfg(2, 1, 1);

        rows.delete();
        for (int i = 0; i < 9; i++) rows.push_back(rnd_row());
        run_map(3, 2, 9, rows);

        start_map(2, 2, 4);
        send_row(mk(30000));
        send_row(mk(29000));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_done", done, 0);
        check("abort_out_row", out_row[0], 0);
        q.delete();

        rows = '{mk(642), mk(905), mk(248), mk(834)};
        run_map(2, 2, 4, rows);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
